// File: rtl/mm_feeder.sv
// mm_feeder: buffers one tile of DEPTH input vectors (each paired with a
// weight), streams the tile to a multiplier in load order, waits for the
// multiplier's done pulse with a timeout, and holds the returned result
// until the consumer takes it.
module mm_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int MAC_NUM      = 8,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             ld_valid_i,
  output logic                             ld_ready_o,
  input  logic [DATA_WIDTH*MAC_NUM-1:0]    ld_data_i,
  input  logic [WEIGHT_WIDTH-1:0]          ld_weight_i,
  output logic                             mm_en_o,
  output logic                             mm_valid_o,
  output logic [DATA_WIDTH*MAC_NUM-1:0]    mm_din_o,
  output logic [WEIGHT_WIDTH-1:0]          mm_win_o,
  input  logic                             mm_done_i,
  input  logic [OUTPUT_WIDTH*MAC_NUM-1:0]  mm_result_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [OUTPUT_WIDTH*MAC_NUM-1:0]  res_data_o,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int VEC_W  = DATA_WIDTH * MAC_NUM;
  localparam int RES_W  = OUTPUT_WIDTH * MAC_NUM;
  localparam int WORD_W = VEC_W + WEIGHT_WIDTH;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic               ld_ready_reg, ld_ready_next;
  logic               mm_en_reg, mm_en_next;
  logic               mm_valid_reg, mm_valid_next;
  logic               res_valid_reg, res_valid_next;
  logic [RES_W-1:0]   res_data_reg, res_data_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;

  // Tile storage; the multiplier-facing word doubles as the registered read port.
  logic [WORD_W-1:0]  buffer_mem [DEPTH];
  logic [WORD_W-1:0]  mm_word_reg;
  logic               wr_en;
  logic               rd_en;
  logic [PTR_W-1:0]   rd_addr;

  // Only the FILL state ever advertises ready, so this is the accept strobe.
  assign wr_en = ld_valid_i && ld_ready_reg && (state_reg == ST_FILL);

  // Beat storage: no reset, a new tile always overwrites all DEPTH entries.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      buffer_mem[wr_ptr_reg] <= {ld_data_i, ld_weight_i};
    end
  end

  // Registered read into the multiplier word; holds when not reading.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mm_word_reg <= '0;
    end else if (rd_en) begin
      mm_word_reg <= buffer_mem[rd_addr];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_FILL;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      wait_cnt_reg  <= '0;
      ld_ready_reg  <= 1'b1;
      mm_en_reg     <= 1'b0;
      mm_valid_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      wait_cnt_reg  <= wait_cnt_next;
      ld_ready_reg  <= ld_ready_next;
      mm_en_reg     <= mm_en_next;
      mm_valid_reg  <= mm_valid_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic; output registers are loaded with the values of the
  // state being entered so every output is flop-driven.
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    wait_cnt_next  = wait_cnt_reg;
    ld_ready_next  = ld_ready_reg;
    mm_en_next     = mm_en_reg;
    mm_valid_next  = mm_valid_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    busy_next      = busy_reg;
    err_next       = err_reg;
    rd_en          = 1'b0;
    rd_addr        = '0;

    case (state_reg)
      ST_FILL: begin
        if (wr_en) begin
          wr_ptr_next = wr_ptr_reg + 1'b1;
          if (wr_ptr_reg == PTR_LAST) begin
            // Last beat written: fetch beat 0 so it is on the bus next cycle.
            state_next    = ST_STREAM;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            rd_en         = 1'b1;
            rd_addr       = '0;
            ld_ready_next = 1'b0;
            busy_next     = 1'b1;
            mm_en_next    = 1'b1;
            mm_valid_next = 1'b1;
          end
        end
      end

      ST_STREAM: begin
        if (rd_ptr_reg == PTR_LAST) begin
          // Last beat is on the bus; the word register keeps it during WAIT.
          state_next    = ST_WAIT;
          mm_valid_next = 1'b0;
          wait_cnt_next = '0;
        end else begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
          rd_en       = 1'b1;
          rd_addr     = rd_ptr_reg + 1'b1;
        end
      end

      ST_WAIT: begin
        if (mm_done_i) begin
          // Done wins over the timeout on the final counted cycle.
          state_next     = ST_HOLD;
          res_data_next  = mm_result_i;
          res_valid_next = 1'b1;
          mm_en_next     = 1'b0;
        end else if (wait_cnt_reg == CNT_LAST) begin
          state_next    = ST_FILL;
          err_next      = 1'b1;
          wr_ptr_next   = '0;
          rd_ptr_next   = '0;
          wait_cnt_next = '0;
          ld_ready_next = 1'b1;
          mm_en_next    = 1'b0;
          busy_next     = 1'b0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      ST_HOLD: begin
        if (res_ready_i) begin
          state_next     = ST_FILL;
          res_valid_next = 1'b0;
          wr_ptr_next    = '0;
          rd_ptr_next    = '0;
          wait_cnt_next  = '0;
          ld_ready_next  = 1'b1;
          busy_next      = 1'b0;
        end
      end

      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  assign ld_ready_o  = ld_ready_reg;
  assign mm_en_o     = mm_en_reg;
  assign mm_valid_o  = mm_valid_reg;
  assign mm_din_o    = mm_word_reg[WORD_W-1:WEIGHT_WIDTH];
  assign mm_win_o    = mm_word_reg[WEIGHT_WIDTH-1:0];
  assign res_valid_o = res_valid_reg;
  assign res_data_o  = res_data_reg;
  assign busy_o      = busy_reg;
  assign err_o       = err_reg;

endmodule

// File: doc/mm_feeder.md
MM_FEEDER -- requirements
Module: mm_feeder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, per-lane input width; WEIGHT_WIDTH, default 8, weight width; OUTPUT_WIDTH, default 8, per-lane result width; MAC_NUM, default 8, lane count; DEPTH, default 8, beats per tile (power of 2, >=2); TIMEOUT, default 64, max WAIT cycles.
REQ-002 Ports SHALL be:
 clk_i  in  1  sole clock, rising edge;
 rst_i  in  1  synchronous, active-high reset;
 ld_valid_i  in  1  load beat valid;
 ld_ready_o  out  1  load beat accepted when high with ld_valid_i;
 ld_data_i  in  DATA_WIDTH*MAC_NUM  one input vector, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH];
 ld_weight_i  in  WEIGHT_WIDTH  weight paired with the beat;
 mm_en_o  out  1  multiplier enable;
 mm_valid_o  out  1  multiplier beat valid;
 mm_din_o  out  DATA_WIDTH*MAC_NUM  multiplier vector;
 mm_win_o  out  WEIGHT_WIDTH  multiplier weight;
 mm_done_i  in  1  multiplier done;
 mm_result_i  in  OUTPUT_WIDTH*MAC_NUM  multiplier result;
 res_valid_o  out  1  result available;
 res_ready_i  in  1  result consumer ready;
 res_data_o  out  OUTPUT_WIDTH*MAC_NUM  captured result;
 busy_o  out  1  high in any state except FILL;
 err_o  out  1  sticky timeout flag.
REQ-003 Clock SHALL be clk_i only; reset SHALL be rst_i, synchronous, active-high.

Function
REQ-004 FSM SHALL have states FILL, STREAM, WAIT, HOLD; all outputs SHALL be registered.
REQ-005 FILL: ld_ready_o=1; each ld_valid_i&ld_ready_o cycle SHALL write {ld_data_i, ld_weight_i} into buffer[wr_ptr] and increment wr_ptr.
REQ-006 Accepting beat DEPTH-1 SHALL move to STREAM next cycle with ld_ready_o=0; no beat beyond DEPTH SHALL be accepted.
REQ-007 STREAM: for exactly DEPTH consecutive cycles mm_valid_o=1, mm_din_o/mm_win_o=buffer[rd_ptr], rd_ptr 0..DEPTH-1 in load order; no gaps.
REQ-008 mm_en_o SHALL be 1 in STREAM and WAIT, 0 in FILL and HOLD.
REQ-009 After the last STREAM beat the FSM SHALL enter WAIT with mm_valid_o=0; mm_din_o/mm_win_o SHALL hold last values.
REQ-010 WAIT: first cycle with mm_done_i=1 SHALL capture mm_result_i into res_data_o and enter HOLD with res_valid_o=1 next cycle.
REQ-011 WAIT SHALL count cycles from 0; if count reaches TIMEOUT-1 without mm_done_i, err_o SHALL set (sticky until reset), no result produced, FSM to FILL with pointers cleared.
REQ-012 mm_done_i together with count=TIMEOUT-1 SHALL be treated as done (capture, no error).
REQ-013 mm_done_i in FILL, STREAM or HOLD SHALL be ignored.
REQ-014 HOLD: res_valid_o and res_data_o SHALL stay stable until res_ready_i=1; that handshake cycle SHALL move to FILL with res_valid_o=0 and wr_ptr=rd_ptr=0.
REQ-015 res_ready_i outside HOLD SHALL have no effect; ld_valid_i outside FILL SHALL be ignored (not stored).
REQ-016 busy_o SHALL be 0 in FILL, 1 otherwise.
REQ-017 Width rule: result bits SHALL pass unmodified; no arithmetic in this block.

Reset
REQ-018 rst_i=1 SHALL force state=FILL, wr_ptr=rd_ptr=wait count=0, ld_ready_o=1, mm_en_o=0, mm_valid_o=0, mm_din_o=0, mm_win_o=0, res_valid_o=0, res_data_o=0, busy_o=0, err_o=0.
REQ-019 Reset in any state, including mid-STREAM, SHALL abort in the next cycle; buffer contents need not clear; the next tile SHALL require DEPTH fresh beats.

Verification
REQ-020 Load beats k=0..7 with lane i=8*k+i, weight=k -> STREAM 8 contiguous mm_valid_o cycles in order, mm_en_o=1, busy_o=1.
REQ-021 mm_done_i=1 three cycles into WAIT with mm_result_i=64'h0123456789ABCDEF -> res_valid_o=1 next cycle, res_data_o=64'h0123456789ABCDEF.
REQ-022 res_ready_i=0 for 5 cycles in HOLD, then 1 -> data stable 6 cycles, FILL next cycle, ld_ready_o=1.
REQ-023 No mm_done_i for 64 WAIT cycles -> err_o=1 sticky, res_valid_o never 1, FSM to FILL.
REQ-024 ld_valid_i with gaps (every other cycle) -> exactly 8 beats stored; ld_valid_i during STREAM ignored; mm_done_i during STREAM ignored.
REQ-025 rst_i=1 on the 4th STREAM beat -> next cycle all outputs at REQ-018 values; full new tile streams correctly afterwards.
